// File: rtl/rf_wb_arbiter_if.sv
// Register-file write-back arbitration bundle.
// Pipeline WB request, MUL/DIV result handshake, hazard lookup, RF write port.
interface rf_wb_arbiter_if;
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        pipe_stall;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output p_valid, p_addr, p_data,
        output md_valid, md_addr, md_data,
        output md_issue, md_issue_rd, rs1, rs2,
        input  md_ready, pipe_stall,
        input  rs1_pending, rs2_pending,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  p_valid, p_addr, p_data,
        input  md_valid, md_addr, md_data,
        input  md_issue, md_issue_rd, rs1, rs2,
        output md_ready, pipe_stall,
        output rs1_pending, rs2_pending,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the single RF write port between pipeline WB and MUL/DIV,
// with starvation forcing and a pending-write scoreboard for decode.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rf_wb_arbiter_if.slave bus
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             r_pipe_stall;

    logic             w_p_grant;
    logic             w_md_ready;
    logic             w_md_grant;
    logic             w_grant;
    logic [4:0]       w_gnt_addr;
    logic [31:0]      w_gnt_data;
    logic             w_gnt_nz;

    logic             r_rf_we;
    logic             r_we_md;
    logic [4:0]       r_rf_waddr;
    logic [31:0]      r_rf_wdata;

    logic [31:0]      r_pend;
    logic [31:0]      w_pend_set;
    logic [31:0]      w_pend_clr;

    // Arbitration: pipeline wins in NORMAL; FORCE hands one slot to MUL/DIV.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_p_grant      = 1'b0;
        w_md_ready     = 1'b0;
        unique case (r_state)
            ST_NORMAL: begin
                if (bus.p_valid) begin
                    w_p_grant = 1'b1;
                end else begin
                    w_md_ready = bus.md_valid;
                end
                if (bus.md_valid && bus.p_valid) begin
                    w_wait_cnt_nxt = r_wait_cnt + LP_ONE;
                    if (w_wait_cnt_nxt == LP_LIMIT) begin
                        w_state_nxt = ST_FORCE;
                    end
                end else begin
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_FORCE: begin
                w_md_ready     = 1'b1;
                w_state_nxt    = ST_NORMAL;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    assign w_md_grant = w_md_ready && bus.md_valid;
    assign w_grant    = w_p_grant || w_md_grant;
    assign w_gnt_addr = w_md_grant ? bus.md_addr : bus.p_addr;
    assign w_gnt_data = w_md_grant ? bus.md_data : bus.p_data;
    assign w_gnt_nz   = (w_gnt_addr != 5'd0);

    // FSM state, starvation counter and the registered stall flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_NORMAL;
            r_wait_cnt   <= '0;
            r_pipe_stall <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_pipe_stall <= (w_state_nxt == ST_FORCE);
        end
    end

    // Registered RF write stage; address/data hold when nothing is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rf_we    <= 1'b0;
            r_we_md    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            r_rf_we <= w_grant && w_gnt_nz;
            r_we_md <= w_md_grant && w_gnt_nz;
            if (w_grant) begin
                r_rf_waddr <= w_gnt_addr;
                r_rf_wdata <= w_gnt_data;
            end
        end
    end

    // Scoreboard set/clear masks; clear fires when an MD write commits.
    always_comb begin
        w_pend_set = '0;
        w_pend_clr = '0;
        if (bus.md_issue && (bus.md_issue_rd != 5'd0)) begin
            w_pend_set[bus.md_issue_rd] = 1'b1;
        end
        if (r_rf_we && r_we_md) begin
            w_pend_clr[r_rf_waddr] = 1'b1;
        end
    end

    // Pending-write bits; set beats clear, x0 never pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_pend_clr) | w_pend_set)
                      & 32'hFFFF_FFFE;
        end
    end

    assign bus.md_ready    = w_md_ready;
    assign bus.pipe_stall  = r_pipe_stall;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_waddr    = r_rf_waddr;
    assign bus.rf_wdata    = r_rf_wdata;
    assign bus.rs1_pending = r_pend[bus.rs1] && (bus.rs1 != 5'd0);
    assign bus.rs2_pending = r_pend[bus.rs2] && (bus.rs2 != 5'd0);

endmodule
